instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset, which SHALL be word-aligned.
REQ-002 Parameter TIMEOUT, default 255: the maximum number of WAIT cycles before a fetch error; range 1..255.
REQ-003 clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 enable  in  1: fetch enable.
REQ-006 imem_req  out  1: instruction-memory read request, one-cycle pulse.
REQ-007 imem_addr  out  32: fetch address, equal to pc_out.
REQ-008 imem_rvalid  in  1: the read-data-valid strobe from instruction memory.
REQ-009 imem_rdata  in  32: read data, sampled only when imem_rvalid=1 in WAIT.
REQ-010 instr_valid  out  1: the held instruction is valid for decode.
REQ-011 instr_ready  in  1: the downstream stage accepts the held instruction.
REQ-012 instruction  out  32: the held instruction word.
REQ-013 opcode  out  7: equal to instruction[6:0]; this is the control-unit opcode input.
REQ-014 pc_out  out  32: the PC of the current or held fetch.
REQ-015 branch_taken  in  1: redirect request, qualified by the handshake.
REQ-016 branch_target  in  32: the redirect address.
REQ-017 fetch_error  out  1: sticky error flag.
REQ-018 instr_count  out  32: count of accepted instructions.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and ERROR; all outputs SHALL be registered or decoded from state, except opcode, which is a slice of instruction.
REQ-020 IDLE->REQ SHALL occur when enable=1; otherwise the FSM SHALL stay in IDLE.
REQ-021 REQ SHALL assert imem_req=1 with imem_addr=pc_out for exactly one cycle, then go to WAIT.
REQ-022 In WAIT with imem_rvalid=1: the unit SHALL register instruction<=imem_rdata and instr_valid<=1, then go to HOLD; instr_valid therefore rises one cycle after rvalid is sampled.
REQ-023 The minimum enable-to-instr_valid latency SHALL be 3 cycles: REQ, WAIT with rvalid, then HOLD.
REQ-024 In HOLD, instr_valid and instruction SHALL remain stable until instr_ready=1.
REQ-025 Handshake (HOLD, instr_ready=1): pc<=branch_taken ? branch_target : pc+4, with the addition mod 2^32 (0xFFFF_FFFC+4 wraps to 0); instr_valid<=0; instr_count<=instr_count+1, wrapping at 2^32.
REQ-026 After the handshake, the FSM SHALL go to REQ if enable=1, else to IDLE.
REQ-027 branch_taken and branch_target SHALL be ignored outside a handshake cycle.
REQ-028 branch_taken=1 with branch_target[1:0]!=0 at handshake: the PC SHALL NOT update, fetch_error SHALL be set to 1, instr_count SHALL still increment, and the FSM SHALL go to ERROR.
REQ-029 WAIT SHALL count cycles without rvalid; when the count reaches TIMEOUT, fetch_error SHALL be set to 1 and the FSM SHALL go to ERROR.
REQ-030 ERROR SHALL be absorbing: no imem_req, instr_valid=0, fetch_error=1, exit only by reset.
REQ-031 imem_rvalid outside WAIT SHALL be ignored.
REQ-032 enable dropping during REQ, WAIT or HOLD SHALL NOT abort the fetch; the FSM SHALL complete to the handshake, then go to IDLE.
REQ-033 instr_ready asserted outside HOLD SHALL have no effect.

Reset
REQ-034 While reset=1, regardless of clock: state=IDLE, pc_out=RESET_PC, imem_req=0, instr_valid=0, instruction=0, opcode=0, fetch_error=0, instr_count=0, timeout counter=0.
REQ-035 Reset asserted mid-fetch SHALL discard the in-flight fetch; a late rvalid after reset SHALL be ignored per REQ-031.

Verification
REQ-036 Reset, enable=1, rvalid one cycle after req with rdata=32'h0000_0033, instr_ready=1 -> imem_addr=0; instr_valid at cycle 3; opcode=7'b0110011; next imem_addr=4; instr_count=1.
REQ-037 Hold instr_ready=0 for 5 cycles with rdata=32'h0000_2003 -> instr_valid and instruction stable throughout; no imem_req; pc_out unchanged.
REQ-038 Handshake with branch_taken=1, branch_target=32'h0000_0100 -> next imem_addr=32'h100; branch_taken=1 outside the handshake -> no effect.
REQ-039 Handshake with branch_target=32'h0000_0102 -> fetch_error=1, ERROR state, no further imem_req until reset; pc_out unchanged.
REQ-040 No rvalid for TIMEOUT=4 cycles -> fetch_error=1 after 4 WAIT cycles; a subsequent rvalid -> ignored.
REQ-041 PC=32'hFFFF_FFFC, handshake -> next imem_addr=0; reset asserted during WAIT -> all outputs at reset values immediately, and a later rvalid produces no instr_valid.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at the current PC,
// holds it for decode until accepted, then advances sequentially or to a branch target.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [31:0] pc_out,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_error,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;

    logic handshake;
    logic misaligned;
    logic timeout_hit;

    assign handshake   = (state == HOLD) && instr_ready;
    assign misaligned  = branch_taken && (branch_target[1:0] != 2'b00);
    // The timeout fires on the TIMEOUT-th consecutive WAIT cycle without data.
    assign timeout_hit = (state == WAIT) && !imem_rvalid && (wait_cnt == TIMEOUT_LAST);

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign opcode    = instruction[6:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    next_state = HOLD;
                end else if (timeout_hit) begin
                    next_state = ERROR;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (misaligned) begin
                        next_state = ERROR;
                    end else if (enable) begin
                        next_state = REQ;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            ERROR: begin
                next_state = ERROR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            wait_cnt    <= 8'd0;
            instruction <= 32'd0;
            instr_valid <= 1'b0;
            fetch_error <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            case (state)
                REQ: begin
                    wait_cnt <= 8'd0;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        fetch_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        // A misaligned redirect leaves the PC at the faulting fetch.
                        if (misaligned) begin
                            fetch_error <= 1'b1;
                        end else if (branch_taken) begin
                            pc <= branch_target;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                ERROR: begin
                    instr_valid <= 1'b0;
                    fetch_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch protocol.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [31:0] pc_out;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        fetch_error;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_mis = 0;

    instruction_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .opcode       (opcode),
        .pc_out       (pc_out),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_error  (fetch_error),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_pc"},    pc_out,           32'd0);
        check({tag, "_addr"},  imem_addr,        32'd0);
        check({tag, "_instr"}, instruction,      32'd0);
        check({tag, "_opc"},   32'(opcode),      32'd0);
        check({tag, "_err"},   32'(fetch_error), 32'd0);
        check({tag, "_cnt"},   instr_count,      32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; imem_rvalid = 1'b0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the word should be held.
    task automatic serve(input logic [31:0] data);
        int n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("serve_req_seen", 32'(imem_req), 32'd1);
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic handshake(input logic taken, input logic [31:0] target);
        instr_ready = 1'b1; branch_taken = taken; branch_target = target;
        @(negedge clk);
        instr_ready = 1'b0; branch_taken = 1'b0;
    endtask

    logic        outstanding, holding, just_req, exp_req, hs, idle_before;
    int          delay;
    logic [31:0] exp_pc, exp_cnt, exp_instr, tgt;

    initial begin
        // Reset and first fetch with minimum latency.
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'd0);
        check("t1_valid_c1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1_req_wait", 32'(imem_req), 32'd0);
        check("t1_valid_c2", 32'(instr_valid), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t1_valid_c3", 32'(instr_valid), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h33);
        handshake(1'b0, 32'd0);
        check("t1_next_req", 32'(imem_req), 32'd1);
        check("t1_next_addr", imem_addr, 32'd4);
        check("t1_count", instr_count, 32'd1);

        // Held instruction under back-pressure; branch outside handshake ignored.
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_2003;
        @(negedge clk);
        imem_rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t2_valid", 32'(instr_valid), 32'd1);
            check("t2_instr", instruction, 32'h0000_2003);
            check("t2_noreq", 32'(imem_req), 32'd0);
            check("t2_pc", pc_out, 32'd4);
            @(negedge clk);
        end
        handshake(1'b1, 32'h0000_0100);
        check("t3_branch_addr", imem_addr, 32'h0000_0100);
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_count", instr_count, 32'd2);

        // Misaligned branch target -> sticky error.
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_rvalid = 1'b0;
        handshake(1'b1, 32'h0000_0102);
        for (int k = 0; k < 5; k++) begin
            check("t4_err", 32'(fetch_error), 32'd1);
            check("t4_noreq", 32'(imem_req), 32'd0);
            check("t4_novalid", 32'(instr_valid), 32'd0);
            check("t4_pc", pc_out, 32'h0000_0100);
            check("t4_count", instr_count, 32'd3);
            imem_rvalid = k[0];
            @(negedge clk);
        end
        imem_rvalid = 1'b0;

        // Fetch timeout after four silent WAIT cycles.
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        check("t5_req", 32'(imem_req), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_err_early", 32'(fetch_error), 32'd0);
        end
        @(negedge clk);
        check("t5_err", 32'(fetch_error), 32'd1);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        @(negedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t5_late_valid", 32'(instr_valid), 32'd0);
        check("t5_late_req", 32'(imem_req), 32'd0);

        // PC wrap at the top of the address space.
        do_reset();
        enable = 1'b1;
        serve(32'h0000_0033);
        handshake(1'b1, 32'hFFFF_FFFC);
        check("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
        serve(32'h0000_0013);
        handshake(1'b0, 32'd0);
        check("t6_wrap_addr", imem_addr, 32'd0);
        check("t6_wrap_req", 32'(imem_req), 32'd1);
        check("t6_count", instr_count, 32'd2);

        // Asynchronous reset during WAIT, then a late rvalid.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("t7_async");
        @(negedge clk);
        reset = 1'b0; enable = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5677;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t7_late_valid", 32'(instr_valid), 32'd0);
            check("t7_late_req", 32'(imem_req), 32'd0);
        end
        imem_rvalid = 1'b0;

        // Randomized run against the protocol model.
        do_reset();
        exp_pc = 32'd0; exp_cnt = 32'd0; exp_instr = 32'd0;
        exp_req = 1'b0; outstanding = 1'b0; holding = 1'b0; delay = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            check("rnd_req", 32'(imem_req), 32'(exp_req));
            check("rnd_pc", pc_out, exp_pc);
            check("rnd_addr", imem_addr, exp_pc);
            check("rnd_count", instr_count, exp_cnt);
            check("rnd_valid", 32'(instr_valid), 32'(holding));
            check("rnd_err", 32'(fetch_error), 32'd0);
            if (holding) begin
                check("rnd_instr", instruction, exp_instr);
                check("rnd_opcode", 32'(opcode), {25'd0, exp_instr[6:0]});
            end

            just_req = exp_req;
            if (exp_req) begin
                outstanding = 1'b1;
                delay = $urandom_range(1, 3);
            end
            idle_before = !outstanding && !holding;

            enable        = ($urandom_range(0, 9) < 8);
            instr_ready   = 1'(($urandom_range(0, 1)));
            branch_taken  = 1'(($urandom_range(0, 1)));
            branch_target = $urandom;
            imem_rdata    = $urandom;
            imem_rvalid   = 1'b0;
            hs = 1'b0;

            if (holding && instr_ready) begin
                hs = 1'b1;
                tgt = branch_target;
                tgt[1:0] = 2'b00;
                branch_target = tgt;
                exp_pc  = branch_taken ? tgt : exp_pc + 32'd4;
                exp_cnt = exp_cnt + 32'd1;
                holding = 1'b0;
            end

            if (outstanding && !just_req) begin
                delay--;
                if (delay == 0) begin
                    imem_rvalid = 1'b1;
                    exp_instr   = imem_rdata;
                    outstanding = 1'b0;
                    holding     = 1'b1;
                end
            end else begin
                imem_rvalid = ($urandom_range(0, 3) == 0);
            end

            exp_req = enable && (hs || idle_before);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
